// File: rtl/bsg_global_buffer_ro_requester_if.sv
// Command, ring and consumer signals of the read-only global buffer requester.
// master = requester side, slave = environment side (command source, ring, consumer).
interface bsg_global_buffer_ro_requester_if #(
  parameter int data_width_p = 16,
  parameter int x_width_p    = 2,
  parameter int bank_width_p = 3,
  parameter int len_width_p  = 16
);
  logic [x_width_p-1:0]              my_x_i;
  logic [x_width_p+bank_width_p-1:0] cmd_addr_i;
  logic [len_width_p-1:0]            cmd_len_i;
  logic                              cmd_v_i;
  logic                              cmd_ready_o;
  logic [bank_width_p-1:0]           ro_addr_o;
  logic [x_width_p-1:0]              ro_dest_x_o;
  logic                              ro_addr_v_o;
  logic [data_width_p-1:0]           ro_data_i;
  logic                              ro_data_v_i;
  logic [data_width_p-1:0]           data_o;
  logic                              v_o;
  logic                              yumi_i;
  logic                              done_o;

  modport master (
    input  my_x_i, cmd_addr_i, cmd_len_i, cmd_v_i, ro_data_i, ro_data_v_i, yumi_i,
    output cmd_ready_o, ro_addr_o, ro_dest_x_o, ro_addr_v_o, data_o, v_o, done_o
  );

  modport slave (
    output my_x_i, cmd_addr_i, cmd_len_i, cmd_v_i, ro_data_i, ro_data_v_i, yumi_i,
    input  cmd_ready_o, ro_addr_o, ro_dest_x_o, ro_addr_v_o, data_o, v_o, done_o
  );
endinterface

// File: rtl/bsg_global_buffer_ro_requester.sv
// Streams a linear range of words out of tile-interleaved read-only banks on a ring,
// with credit-limited issue into a response FIFO feeding the consumer.
module bsg_global_buffer_ro_requester #(
  parameter int data_width_p    = -1,
  parameter int bank_els_p      = -1,
  parameter int num_tiles_x_p   = -1,
  parameter int resp_fifo_els_p = 4,
  parameter int len_width_p     = 16
) (
  input logic                           clk_i,
  input logic                           reset_i,
  bsg_global_buffer_ro_requester_if.master io
);
  localparam int x_w   = $clog2(num_tiles_x_p);
  localparam int b_w   = $clog2(bank_els_p);
  localparam int a_w   = x_w + b_w;
  localparam int c_w   = $clog2(resp_fifo_els_p + 1);
  localparam int p_w   = (resp_fifo_els_p > 1) ? $clog2(resp_fifo_els_p) : 1;
  localparam int ign_w = $clog2(resp_fifo_els_p + num_tiles_x_p + 1);
  localparam logic [c_w-1:0] els_c  = c_w'(resp_fifo_els_p);
  localparam logic [p_w-1:0] last_p = p_w'(resp_fifo_els_p - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e                  r_state;
  logic [a_w-1:0]          r_cur_addr;
  logic [len_width_p-1:0]  r_remaining;
  logic [c_w-1:0]          r_credits, r_outst, r_cnt;
  logic [p_w-1:0]          r_rd, r_wr;
  logic [data_width_p-1:0] r_mem [resp_fifo_els_p];
  logic                    r_cmd_ready, r_done;
  logic [ign_w-1:0]        r_ign;

  logic w_cmd_fire, w_issue, w_deq, w_full, w_ret, w_enq, w_last;

  assign w_cmd_fire = io.cmd_v_i & r_cmd_ready;
  assign w_issue    = (r_state == ISSUE) && (r_remaining != '0) && (r_credits != '0);
  assign w_deq      = io.yumi_i && (r_cnt != '0);
  assign w_full     = (r_cnt == els_c);
  // Returns with nothing outstanding are stale (e.g. from before a reset) and dropped.
  assign w_ret      = io.ro_data_v_i && (r_outst != '0);
  assign w_enq      = w_ret && (!w_full || w_deq);
  assign w_last     = (r_state == DRAIN) && (r_outst == '0) && (r_cnt == c_w'(1)) && w_deq;

  assign io.cmd_ready_o = r_cmd_ready;
  assign io.done_o      = r_done;
  assign io.ro_addr_v_o = w_issue;
  // Low address bits pick the tile, so consecutive words hit consecutive tiles.
  assign io.ro_dest_x_o = r_cur_addr[x_w-1:0];
  assign io.ro_addr_o   = r_cur_addr[a_w-1:x_w];
  assign io.v_o         = (r_cnt != '0);
  assign io.data_o      = r_mem[r_rd];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= IDLE;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_cmd_ready <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_cmd_fire) begin
            if (io.cmd_len_i == '0) begin
              r_done <= 1'b1;
            end else begin
              r_cmd_ready <= 1'b0;
              r_cur_addr  <= io.cmd_addr_i;
              r_remaining <= io.cmd_len_i;
              r_state     <= ISSUE;
            end
          end
        end
        ISSUE: if (w_issue) begin
          r_cur_addr  <= r_cur_addr + a_w'(1);
          r_remaining <= r_remaining - len_width_p'(1);
          if (r_remaining == len_width_p'(1)) r_state <= DRAIN;
        end
        DRAIN: if (w_last) begin
          r_state     <= IDLE;
          r_cmd_ready <= 1'b1;
          r_done      <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // credits + outstanding + occupancy always sum to the FIFO depth.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_credits <= els_c;
      r_outst   <= '0;
      r_cnt     <= '0;
      r_rd      <= '0;
      r_wr      <= '0;
      r_ign     <= ign_w'(resp_fifo_els_p + num_tiles_x_p);
    end else begin
      if (w_issue && !w_deq)      r_credits <= r_credits - c_w'(1);
      else if (w_deq && !w_issue) r_credits <= r_credits + c_w'(1);
      if (w_issue && !w_ret)      r_outst <= r_outst + c_w'(1);
      else if (w_ret && !w_issue) r_outst <= r_outst - c_w'(1);
      if (w_enq && !w_deq)        r_cnt <= r_cnt + c_w'(1);
      else if (w_deq && !w_enq)   r_cnt <= r_cnt - c_w'(1);
      if (w_enq) r_wr <= (r_wr == last_p) ? '0 : r_wr + p_w'(1);
      if (w_deq) r_rd <= (r_rd == last_p) ? '0 : r_rd + p_w'(1);
      if (r_ign != '0) r_ign <= r_ign - ign_w'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wr] <= io.ro_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(io.ro_data_v_i && w_full && !w_deq))
        else $error("ro requester x=%0d: response into full fifo", io.my_x_i);
      assert (!(io.ro_data_v_i && (r_state == IDLE) && (r_outst == '0) && (r_ign == '0)))
        else $error("ro requester x=%0d: response with nothing outstanding", io.my_x_i);
      assert (!io.yumi_i || io.v_o)
        else $error("ro requester x=%0d: yumi without valid", io.my_x_i);
    end
  end
endmodule
